// File: rtl/cpu_pkg.sv
// Shared definitions for the 6-bit core sequencer.
// Contents:
//   - FSM state encodings (IDLE, FETCH, DECODE, EXEC, HALT)
//   - instruction class constants and field positions
//   - decode_cls(): maps an instruction word to its execution class
//   - instr_reg():  extracts the register field of an instruction word
package cpu_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    // Instruction group values selecting the execution class
    localparam logic [3:0] CLS_ALU_MAX = 4'd6;
    localparam logic [3:0] CLS_STORE   = 4'd7;
    localparam logic [3:0] CLS_HALT    = 4'd15;

    // Instruction field positions
    localparam int unsigned INSTR_GRP_MSB = 5;
    localparam int unsigned INSTR_GRP_LSB = 2;
    localparam int unsigned INSTR_REG_MSB = 1;
    localparam int unsigned INSTR_REG_LSB = 0;

    // Width of the fetch timeout counter; holds ACK_TIMEOUT up to 255
    localparam int unsigned TMO_WIDTH = 8;

    typedef enum logic [1:0] {
        ClsAlu,
        ClsStore,
        ClsNop,
        ClsHalt
    } instr_cls_e;

    function automatic instr_cls_e decode_cls(input logic [5:0] instr);
        logic [3:0] grp;
        grp = instr[INSTR_GRP_MSB:INSTR_GRP_LSB];
        if (grp <= CLS_ALU_MAX) begin
            return ClsAlu;
        end else if (grp == CLS_STORE) begin
            return ClsStore;
        end else if (grp == CLS_HALT) begin
            return ClsHalt;
        end
        return ClsNop;
    endfunction

    function automatic logic [1:0] instr_reg(input logic [5:0] instr);
        return instr[INSTR_REG_MSB:INSTR_REG_LSB];
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Loadable up-counter with clear/enable and an expiry flag, used to bound
// bus handshake waits.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr_i        clear count to zero (highest priority)
//   en_i         increment by one
//   load_i       load load_val_i (priority below clear, above enable)
//   load_val_i   value to load
//   limit_i      expiry limit
//   expired_o    high in an enabled cycle whose increment reaches limit_i,
//                so the owner can react in that same cycle
module fetch_timeout_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic [Width-1:0] limit_i,
    output logic             expired_o
);

    logic [Width-1:0] count_q, count_d;
    logic [Width-1:0] count_inc;

    assign count_inc = count_q + Width'(1);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_inc;
        end
    end

    assign expired_o = en_i && !clr_i && !load_i && (count_inc == limit_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 6-bit core. Owns the program
// counter, fetches over a req/ack handshake, holds the instruction register
// and emits one-cycle commit strobes in EXEC.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   run_i             level: execute continuously
//   step_i            pulse: execute one instruction (honoured only in IDLE)
//   imem_req_o        fetch request (high exactly while in FETCH)
//   imem_addr_o       fetch address (= pc)
//   imem_rdata_i      instruction word, valid with imem_ack_i
//   imem_ack_i        fetch acknowledge
//   instr_o           instruction register
//   aku_strobe_o      accumulator commit pulse (ALU class, EXEC only)
//   reg_we_strobe_o   register-file write qualifier (store class, EXEC only)
//   pc_o              program counter
//   busy_o            high in FETCH/DECODE/EXEC
//   halted_o          high in HALT
//   fault_o           sticky fetch-timeout flag
module cpu_sequencer #(
    parameter int unsigned         PC_WIDTH    = 8,
    parameter int unsigned         ACK_TIMEOUT = 15,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run_i,
    input  logic                step_i,
    output logic                imem_req_o,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic [5:0]          imem_rdata_i,
    input  logic                imem_ack_i,
    output logic [5:0]          instr_o,
    output logic                aku_strobe_o,
    output logic                reg_we_strobe_o,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                busy_o,
    output logic                halted_o,
    output logic                fault_o
);

    import cpu_pkg::*;

    logic [2:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [5:0]          instr_q, instr_d;
    logic                fault_q, fault_d;

    logic       in_fetch;
    logic       tmo_expired;
    instr_cls_e cls;

    assign in_fetch = (state_q == ST_FETCH);
    assign cls      = decode_cls(instr_q);

    // Counts wait cycles of the current fetch; cleared outside FETCH and on ack.
    fetch_timeout_counter #(
        .Width(TMO_WIDTH)
    ) u_fetch_timeout_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!in_fetch || imem_ack_i),
        .en_i      (in_fetch && !imem_ack_i),
        .load_i    (1'b0),
        .load_val_i('0),
        .limit_i   (TMO_WIDTH'(ACK_TIMEOUT)),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (run_i || step_i) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_ack_i) begin
                    instr_d = imem_rdata_i;
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = ST_DECODE;
                end else if (tmo_expired) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (cls == ClsHalt) begin
                    state_d = ST_HALT;
                end else if (run_i) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 6'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    // Outputs are decoded from registered state only, so reset drops req at once.
    assign imem_req_o      = in_fetch;
    assign imem_addr_o     = pc_q;
    assign instr_o         = instr_q;
    assign pc_o            = pc_q;
    assign aku_strobe_o    = (state_q == ST_EXEC) && (cls == ClsAlu);
    assign reg_we_strobe_o = (state_q == ST_EXEC) && (cls == ClsStore);
    assign busy_o          = (state_q == ST_FETCH) || (state_q == ST_DECODE)
                          || (state_q == ST_EXEC);
    assign halted_o        = (state_q == ST_HALT);
    assign fault_o         = fault_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, step, ack;
    logic [5:0] rdata;
    logic       req;
    logic [7:0] addr;
    logic [5:0] instr;
    logic       aku, rwe;
    logic [7:0] pc;
    logic       busy, halted, fault;

    int         n_cmp = 0;
    int         n_err = 0;
    int         mpc;
    logic [5:0] minstr;

    always #5 clk = ~clk;

    cpu_sequencer #(
        .PC_WIDTH   (8),
        .ACK_TIMEOUT(15),
        .RESET_PC   (8'd0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run_i          (run),
        .step_i         (step),
        .imem_req_o     (req),
        .imem_addr_o    (addr),
        .imem_rdata_i   (rdata),
        .imem_ack_i     (ack),
        .instr_o        (instr),
        .aku_strobe_o   (aku),
        .reg_we_strobe_o(rwe),
        .pc_o           (pc),
        .busy_o         (busy),
        .halted_o       (halted),
        .fault_o        (fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Class by instruction group: 0 ALU, 1 store, 2 NOP, 3 HALT
    function automatic int cls_of(input logic [5:0] w);
        int g;
        g = int'(w) / 4;
        if (g <= 6) return 0;
        if (g == 7) return 1;
        if (g == 15) return 3;
        return 2;
    endfunction

    // Entered at the falling edge of the first FETCH cycle. Serves the fetch
    // after 'waits' wait cycles, then checks DECODE, EXEC and the following
    // state. cont=0 drops run during the fetch; poke_step pulses step while busy.
    task automatic exec_instr(input logic [5:0] w, input int waits, input bit cont,
                              input bit poke_step);
        int c;
        c = cls_of(w);
        for (int i = 0; i <= waits; i++) begin
            chk("fetch_req", req, 1);
            chk("fetch_addr", addr, mpc);
            chk("fetch_busy", busy, 1);
            chk("fetch_instr_hold", instr, minstr);
            chk("fetch_no_strobe", {aku, rwe}, 0);
            if (!cont && i == 0) run = 1'b0;
            ack   = (i == waits);
            rdata = (i == waits) ? w : 6'($urandom);
            @(negedge clk);
        end
        ack    = 1'b0;
        mpc    = (mpc + 1) % 256;
        minstr = w;
        chk("decode_req", req, 0);
        chk("decode_no_strobe", {aku, rwe}, 0);
        chk("decode_instr", instr, w);
        chk("decode_pc", pc, mpc);
        chk("decode_busy", busy, 1);
        if (poke_step) step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("exec_aku", aku, (c == 0) ? 1 : 0);
        chk("exec_rwe", rwe, (c == 1) ? 1 : 0);
        chk("exec_busy", busy, 1);
        chk("exec_req", req, 0);
        @(negedge clk);
        if (c == 3) begin
            chk("halt_halted", halted, 1);
            chk("halt_busy", busy, 0);
            chk("halt_req", req, 0);
            chk("halt_pc", pc, mpc);
        end else if (!cont) begin
            chk("idle_busy", busy, 0);
            chk("idle_req", req, 0);
            chk("idle_halted", halted, 0);
        end
    endtask

    initial begin
        int   waits;
        bit   drop;
        logic [5:0] w;

        rst_n = 1'b0; run = 1'b0; step = 1'b0; ack = 1'b0; rdata = 6'd0;
        repeat (2) @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_strobes", {aku, rwe}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        mpc = 0; minstr = 6'd0;

        // Directed program under run with zero-wait fetches, ending in HALT
        rst_n = 1'b1; run = 1'b1;
        @(negedge clk);
        exec_instr(6'b000101, 0, 1, 0);
        exec_instr(6'b011110, 0, 1, 0);
        exec_instr(6'b001000, 0, 1, 0);
        exec_instr(6'b111100, 0, 1, 0);
        ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("halt_hold_req", req, 0);
            chk("halt_hold_pc", pc, 4);
            chk("halt_hold_instr", instr, 6'b111100);
            chk("halt_hold_halted", halted, 1);
        end
        ack = 1'b0;

        // Step mode: 2-wait fetch, step pulse while busy must be ignored
        run = 1'b0; rst_n = 1'b0;
        #1 chk("async_rst_halted", halted, 0);
        @(negedge clk);
        rst_n = 1'b1; mpc = 0; minstr = 6'd0;
        @(negedge clk);
        chk("idle_wait_req", req, 0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        exec_instr(6'b000000, 2, 0, 1);
        repeat (3) begin
            @(negedge clk);
            chk("step_ignored_req", req, 0);
            chk("step_ignored_busy", busy, 0);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        exec_instr(6'b100000, 0, 0, 0);

        // Fetch timeout: memory never acks
        run = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            chk("tmo_req", req, 1);
            chk("tmo_addr", addr, mpc);
            chk("tmo_fault_low", fault, 0);
            @(negedge clk);
        end
        chk("tmo_fault", fault, 1);
        chk("tmo_halted", halted, 1);
        chk("tmo_req_drop", req, 0);
        chk("tmo_instr", instr, minstr);
        chk("tmo_pc", pc, mpc);

        // Randomized program with random waits, occasional run drops and PC wrap
        rst_n = 1'b0; run = 1'b0;
        @(negedge clk);
        chk("rst_fault_clear", fault, 0);
        rst_n = 1'b1; run = 1'b1; mpc = 0; minstr = 6'd0;
        @(negedge clk);
        for (int n = 0; n < 300; n++) begin
            w     = (n == 299) ? {4'hF, 2'($urandom)} : 6'($urandom_range(0, 59));
            waits = $urandom_range(0, 3);
            drop  = (n != 299) && ($urandom_range(0, 9) == 0);
            exec_instr(w, waits, !drop, 0);
            if (drop) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    chk("rand_idle_req", req, 0);
                end
                run = 1'b1;
                @(negedge clk);
            end
        end

        // Reset asserted during a fetch wait with pc != 0
        rst_n = 1'b0; run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; run = 1'b1; mpc = 0; minstr = 6'd0;
        @(negedge clk);
        exec_instr(6'b000001, 0, 1, 0);
        chk("midfetch_req", req, 1);
        chk("midfetch_addr", addr, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", req, 0);
        chk("async_pc", pc, 0);
        chk("async_busy", busy, 0);
        chk("async_instr", instr, 0);
        @(negedge clk);
        run = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle_req", req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Fetch/decode/execute controller for the 6-bit microprocessor core.
- Holds the program counter and fetches instructions from instruction memory over a req/ack handshake.
- Presents a stable instruction word to the instruction decoder and emits one-cycle strobes that commit accumulator and register-file writes.
- Also provides run/step control, a HALT instruction and a fetch-timeout fault.

Parameters:
- PC_WIDTH, 8, width of program counter and imem_addr; the PC wraps modulo 2^PC_WIDTH.
- ACK_TIMEOUT, 15, maximum cycles to wait for imem_ack before a fault is raised; legal range 1..255.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; while 1 the core executes continuously.
- step  in  1  one-cycle pulse; executes exactly one instruction when IDLE.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_WIDTH  fetch address, equal to pc while imem_req=1.
- imem_rdata  in  6  instruction word, valid when imem_ack=1.
- imem_ack  in  1  fetch acknowledge.
- instr  out  6  instruction register contents, fed to the instruction decoder.
- aku_strobe  out  1  one-cycle commit pulse for the accumulator (ALU class).
- reg_we_strobe  out  1  one-cycle commit pulse qualifying decoder register write enables (store class).
- pc  out  PC_WIDTH  current program counter.
- busy  out  1  high in any state other than IDLE and HALT.
- halted  out  1  high in HALT.
- fault  out  1  sticky; set on fetch timeout.

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - state=IDLE, pc=RESET_PC, instr=6'b0.
  - All strobes, imem_req, busy, halted and fault are 0; the timeout counter is 0.
- Instruction classes, by instr[5:2]:
  - 0..6: ALU class.
  - 7: store class.
  - 8..14: NOP.
  - 15: HALT.
- IDLE:
  - If run=1 or step=1, go to FETCH. Otherwise stay.
  - A step pulse seen in any state other than IDLE is ignored.
- FETCH:
  - imem_req=1 and imem_addr=pc; both are held stable until ack.
  - On imem_ack=1: instr<=imem_rdata, pc<=pc+1 (wraps), clear the counter, go to DECODE.
  - An ack in the same cycle req first rises is legal, giving a zero-wait fetch.
  - Without ack the counter increments. When counter==ACK_TIMEOUT with no ack: fault<=1, imem_req drops, go to HALT.
  - imem_ack outside FETCH is ignored.
- DECODE:
  - One cycle, no outputs change, giving the decoder a settle cycle. Go to EXEC.
- EXEC (one cycle):
  - ALU class: aku_strobe=1.
  - Store class: reg_we_strobe=1.
  - NOP: no strobe.
  - HALT: no strobe; go to HALT.
  - Otherwise, if run=1 go to FETCH, else go to IDLE.
- HALT:
  - halted=1; the state is terminal until rst_n is asserted.
  - pc keeps the address following the HALT instruction.
- Timing and sequencing rules:
  - Latency per instruction is 3 + wait cycles (FETCH, DECODE, EXEC). Back-to-back zero-wait throughput is one instruction per 3 cycles.
  - Dropping run mid-instruction completes the current instruction, then enters IDLE. No fetch is abandoned with req high.
  - The strobes are mutually exclusive and never asserted outside EXEC.
  - instr changes only on a FETCH ack.
- Reset mid-fetch: imem_req drops immediately (asynchronously). Memory must tolerate an abandoned request.

Decomposition:
- Shared package cpu_pkg:
  - State enum: IDLE, FETCH, DECODE, EXEC, HALT.
  - Class constants: CLS_ALU_MAX=4'd6, CLS_STORE=4'd7, CLS_HALT=4'd15.
  - Instruction field positions: group [5:2], register [1:0].
- One natural sub-module: fetch_timeout_counter. It is a loadable counter with clear/enable and an expired flag, reused for any future bus timeouts.
- The FSM and PC stay in cpu_sequencer.

Test Plan:
- Reset, then run=1, with memory acking in the same cycle and rdata=6'b000101 at address 0 → imem_req high in cycle 1, aku_strobe pulses in cycle 3, pc=1, no reg_we_strobe.
- Program {6'b011110, 6'b001000, 6'b111100} with run held high → reg_we_strobe in cycle 3, aku_strobe in cycle 6, halted=1 after cycle 9, pc=3, no further imem_req.
- run=0, step pulse in IDLE with a 2-wait ack and instr=6'b000000 → one instruction, 5 cycles, aku_strobe once, return to IDLE. A second step pulse issued while busy produces nothing.
- Memory never acks, ACK_TIMEOUT=15 → imem_req high for exactly 15 cycles, then fault=1, halted=1, instr unchanged.
- PC_WIDTH=3 with 8 NOPs (6'b100000) under run → imem_addr runs 0..7 then 0, with no strobes.
- Assert rst_n=0 during FETCH wait → imem_req, pc and state return to reset values in the same cycle without waiting for a clock edge.
